// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared bus definitions for the arbiter and the master/slave
//               blocks: arbiter state encoding, the maximum master count and
//               a helper for sizing id/index fields.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWNED    = 2'd1,
        HANDOVER = 2'd2
    } arb_state_t;

    // Width needed to hold an id in 0..n-1, never less than one bit.
    function automatic int slv_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_if.sv
// ============================================================================
// Module      : bus_arbiter_rr_if
// Description : Arbitration bundle between the master ports, the slaves and
//               the round-robin arbiter.
// Ports       : master modport - bus side: drives requests, target ids and
//                                slave split/ready, observes grant state.
//               slave modport  - arbiter side: the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_rr_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3,
    parameter int SLV_W     = 2
);
    logic [N_MASTERS-1:0]       m_req;
    logic [N_MASTERS*SLV_W-1:0] m_slv_id;
    logic                       s_split;
    logic [N_SLAVES-1:0]        s_ready;
    logic [N_MASTERS-1:0]       m_grant;
    logic [N_MASTERS-1:0]       m_parked;
    logic [SLV_W-1:0]           slv_sel;
    logic                       bus_valid;
    logic                       timeout_err;

    modport master (
        output m_req, m_slv_id, s_split, s_ready,
        input  m_grant, m_parked, slv_sel, bus_valid, timeout_err
    );

    modport slave (
        input  m_req, m_slv_id, s_split, s_ready,
        output m_grant, m_parked, slv_sel, bus_valid, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin priority encoder. Scans the request
//               vector starting at index `start` (inclusive), wrapping from
//               N-1 to 0, and returns the first requester.
// Ports       : req   - request vector
//               start - first index to consider
//               grant - one-hot winner (0 when no request)
//               idx   - winner index (0 when no request)
//               any   - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  wire logic [N-1:0]     req,
    input  wire logic [IDX_W-1:0] start,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] idx,
    output logic                  any
);

    always_comb begin
        int  cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < N; i++) begin
            cand = int'(start) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_W'(cand);
            end
        end
        any = found;
    end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_rr.sv
// ============================================================================
// Module      : bus_arbiter_rr
// Description : N-master round-robin bus arbiter with tenure hold and split
//               transaction support. A split parks the holder until its
//               slave raises s_ready; the master is then resumed ahead of
//               ordinary round-robin requesters.
//               Optional macro ARB_TIMEOUT_EN bounds each tenure to MAX_HOLD
//               cycles and pulses timeout_err when a grant is revoked.
// Ports       : clock - bus clock
//               rst   - asynchronous active-low reset
//               bus   - bus_arbiter_rr_if.slave (requests, split/ready in;
//                       grant, parked, slv_sel, bus_valid, timeout_err out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 3,
    parameter int SLV_W     = 2,
    parameter int MAX_HOLD  = 256
) (
    input  wire logic       clock,
    input  wire logic       rst,
    bus_arbiter_rr_if.slave bus
);

    localparam int IDX_W = slv_id_width(N_MASTERS);

    if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || (2**SLV_W) < N_SLAVES ||
        MAX_HOLD < 2) begin : g_param_check
        $error("bus_arbiter_rr: illegal parameter combination");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t             r_state,  w_state;
    logic [N_MASTERS-1:0]   r_grant,  w_grant;
    logic [N_MASTERS-1:0]   r_parked, w_parked;
    logic [N_MASTERS-1:0]   r_resume, w_resume;
    logic [SLV_W-1:0]       r_split_slv [N_MASTERS];
    logic [SLV_W-1:0]       w_split_slv [N_MASTERS];
    logic [SLV_W-1:0]       r_slv_sel, w_slv_sel;
    logic                   r_valid,  w_valid;
    logic [IDX_W-1:0]       r_ptr,    w_ptr;    // also the holder index in OWNED
`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = slv_id_width(MAX_HOLD);
    logic [CNT_W-1:0]       r_tenure, w_tenure;
    logic                   r_timeout, w_timeout;
`endif

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    logic [N_MASTERS-1:0]   w_eligible;
    logic [N_MASTERS-1:0]   w_resume_req;
    logic [IDX_W-1:0]       w_rr_start;
    logic [N_MASTERS-1:0]   w_res_grant, w_rr_grant, w_win_grant;
    logic [IDX_W-1:0]       w_res_idx,   w_rr_idx,   w_win_idx;
    logic                   w_res_any,   w_rr_any;
    logic [SLV_W-1:0]       w_win_slv;
    logic                   w_hold_req;

    assign w_eligible   = bus.m_req & ~r_parked;
    assign w_resume_req = w_eligible & r_resume;
    assign w_rr_start   = (r_ptr == IDX_W'(N_MASTERS - 1)) ? '0 : r_ptr + IDX_W'(1);

    // Resumed masters win outright, lowest index first.
    rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_resume_pick (
        .req   (w_resume_req),
        .start ('0),
        .grant (w_res_grant),
        .idx   (w_res_idx),
        .any   (w_res_any)
    );

    rr_picker #(.N(N_MASTERS), .IDX_W(IDX_W)) u_rr_pick (
        .req   (w_eligible),
        .start (w_rr_start),
        .grant (w_rr_grant),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    assign w_win_grant = w_res_any ? w_res_grant : w_rr_grant;
    assign w_win_idx   = w_res_any ? w_res_idx   : w_rr_idx;
    assign w_win_slv   = bus.m_slv_id[int'(w_win_idx)*SLV_W +: SLV_W];
    assign w_hold_req  = bus.m_req[r_ptr];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state     = r_state;
        w_grant     = r_grant;
        w_parked    = r_parked;
        w_resume    = r_resume;
        w_split_slv = r_split_slv;
        w_slv_sel   = r_slv_sel;
        w_valid     = r_valid;
        w_ptr       = r_ptr;
`ifdef ARB_TIMEOUT_EN
        w_tenure    = r_tenure;
        w_timeout   = 1'b0;
`endif

        // Split resume runs in every state. A park being set this cycle is
        // not yet visible in r_parked, so its slave's ready is seen next cycle.
        for (int m = 0; m < N_MASTERS; m++) begin
            if (r_parked[m] && (int'(r_split_slv[m]) < N_SLAVES) &&
                bus.s_ready[r_split_slv[m]]) begin
                w_parked[m] = 1'b0;
                w_resume[m] = 1'b1;
            end
        end

        case (r_state)
            // HANDOVER is the single dead cycle after a release; arbitrating
            // at its closing edge puts the next grant at release + 2.
            IDLE, HANDOVER: begin
                w_state = IDLE;
                if (w_rr_any) begin
                    w_state             = OWNED;
                    w_grant             = w_win_grant;
                    w_valid             = 1'b1;
                    w_slv_sel           = w_win_slv;
                    w_ptr               = w_win_idx;
                    w_resume[w_win_idx] = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    w_tenure            = '0;
`endif
                end
            end

            OWNED: begin
                if (bus.s_split) begin
                    // Split beats a simultaneous request drop.
                    w_parked[r_ptr]    = 1'b1;
                    w_split_slv[r_ptr] = r_slv_sel;
                    w_grant            = '0;
                    w_valid            = 1'b0;
                    w_state            = HANDOVER;
                end else if (!w_hold_req) begin
                    w_grant = '0;
                    w_valid = 1'b0;
                    w_state = HANDOVER;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_tenure == CNT_W'(MAX_HOLD - 1)) begin
                    // r_ptr stays on the holder, so it drops to the back of
                    // the round-robin order.
                    w_grant   = '0;
                    w_valid   = 1'b0;
                    w_timeout = 1'b1;
                    w_state   = HANDOVER;
                end else begin
                    w_tenure = r_tenure + CNT_W'(1);
                end
`endif
            end

            default: begin
                w_state = IDLE;
                w_grant = '0;
                w_valid = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_parked  <= '0;
            r_resume  <= '0;
            r_slv_sel <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= '0;
            for (int m = 0; m < N_MASTERS; m++) begin
                r_split_slv[m] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            r_tenure  <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state     <= w_state;
            r_grant     <= w_grant;
            r_parked    <= w_parked;
            r_resume    <= w_resume;
            r_slv_sel   <= w_slv_sel;
            r_valid     <= w_valid;
            r_ptr       <= w_ptr;
            r_split_slv <= w_split_slv;
`ifdef ARB_TIMEOUT_EN
            r_tenure    <= w_tenure;
            r_timeout   <= w_timeout;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.m_grant   = r_grant;
    assign bus.m_parked  = r_parked;
    assign bus.slv_sel   = r_slv_sel;
    assign bus.bus_valid = r_valid;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_err = r_timeout;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire
